wb_commit_arbiter: RTL and testbench

//  Parametrised writeback stage. It merges in-order pipeline results (from the MW latch) with
//  out-of-order multdiv completions onto the single regfile write port. Multdiv results wait in a

---
 rtl/wb_commit_arbiter_pkg.sv | 16 +
 rtl/wb_pending_queue.sv | 115 +++++++++++
 rtl/wb_commit_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_commit_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_arbiter_pkg.sv
// Shared encodings and defaults for the writeback commit arbiter.
//   WB_SEL_*       : pipeline writeback data-source select encodings
//   *_REG_DEF      : default architectural register indices
//   SETX_W         : width of the setx immediate (target) field
package wb_commit_arbiter_pkg;

  localparam logic [1:0] WB_SEL_EXEC = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_SETX = 2'd2;
  localparam logic [1:0] WB_SEL_JAL  = 2'd3;

  localparam int unsigned EXC_REG_DEF  = 30;
  localparam int unsigned LINK_REG_DEF = 31;
  localparam int unsigned SETX_W       = 27;

endpackage

// File: rtl/wb_pending_queue.sv
// Circular buffer of pending multdiv register writes.
//   clock, reset            : clock, synchronous active-low reset (flushes all entries)
//   push, push_rd, push_data: enqueue at tail; rd 0 entries are stored already invalid
//   pop                     : retire the head slot (valid or squashed)
//   squash_en, squash_rd    : invalidate every valid entry targeting squash_rd
//   head_valid/rd/data      : head slot contents
//   count                   : occupied slots (valid + squashed)
//   pending_mask            : bit r set while a valid entry targets r
module wb_pending_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [REG_AW-1:0]       push_rd,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  input  logic                    squash_en,
  input  logic [REG_AW-1:0]       squash_rd,
  output logic                    head_valid,
  output logic [REG_AW-1:0]       head_rd,
  output logic [DATA_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [(2**REG_AW)-1:0]  pending_mask
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NREG = 2**REG_AW;

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [REG_AW-1:0] rd_q    [DEPTH];
  logic [REG_AW-1:0] rd_d    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != CW'(DEPTH));

  // Next-state: squash, then pop, then push (push and squash never target the same slot usefully).
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (squash_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (rd_q[i] == squash_rd)) valid_d[i] = 1'b0;
      end
    end

    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    // New entry is older-than-nothing: it is written after any same-cycle squash.
    if (do_push) begin
      valid_d[tail_q] = (push_rd != '0);
      rd_d[tail_q]    = push_rd;
      data_d[tail_q]  = push_data;
      tail_d          = tail_q + 1'b1;
    end

    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Pending-register mask for the hazard unit.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  assign head_valid = valid_q[head_q] && (count_q != '0);
  assign head_rd    = rd_q[head_q];
  assign head_data  = data_q[head_q];
  assign count      = count_q;

  logic unused_nreg;
  assign unused_nreg = (NREG == 0);

endmodule

// File: rtl/wb_commit_arbiter.sv
// Writeback stage: merges in-order pipeline results with out-of-order multdiv
// completions onto the single regfile write port.
//   clock, reset                 : clock, synchronous active-low reset
//   pipe_*, exec_out, mem_out,
//   target                       : MW latch writeback request and data sources
//   md_valid/md_rd/md_result     : multdiv completion (held while md_ready=0)
//   md_ready                     : queue can accept
//   rf_we/rf_waddr/rf_wdata      : registered regfile write port
//   pending_mask, q_count        : queued-write hazard mask and occupancy
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned EXC_REG  = EXC_REG_DEF,
  parameter int unsigned LINK_REG = LINK_REG_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pipe_valid,
  input  logic [1:0]              pipe_sel,
  input  logic [REG_AW-1:0]       pipe_rd,
  input  logic                    pipe_exc,
  input  logic [DATA_W-1:0]       pipe_exc_code,
  input  logic [DATA_W-1:0]       exec_out,
  input  logic [DATA_W-1:0]       mem_out,
  input  logic [SETX_W-1:0]       target,
  input  logic                    md_valid,
  input  logic [REG_AW-1:0]       md_rd,
  input  logic [DATA_W-1:0]       md_result,
  output logic                    md_ready,
  output logic                    rf_we,
  output logic [REG_AW-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [(2**REG_AW)-1:0]  pending_mask,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [REG_AW-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              q_empty, bypass, push, pop;
  logic              head_valid;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  logic              rf_we_q,    rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  // Pipeline destination/data select; an exception overrides the instruction's own write.
  always_comb begin
    pipe_addr = pipe_rd;
    pipe_data = exec_out;
    if (pipe_exc) begin
      pipe_addr = REG_AW'(EXC_REG);
      pipe_data = pipe_exc_code;
    end else begin
      case (pipe_sel)
        WB_SEL_EXEC: ;
        WB_SEL_MEM:  pipe_data = mem_out;
        WB_SEL_SETX: begin
          pipe_addr = REG_AW'(EXC_REG);
          pipe_data = DATA_W'(target);
        end
        WB_SEL_JAL: begin
          pipe_addr = REG_AW'(LINK_REG);
          pipe_data = exec_out;
        end
        default: ;
      endcase
    end
  end

  // md_ready uses the pre-cycle count, so a full queue never pushes even when it pops.
  assign q_empty  = (q_count == '0);
  assign md_ready = (q_count != CW'(DEPTH));
  assign bypass   = md_valid && q_empty && !pipe_valid;
  assign push     = md_valid && md_ready && !bypass;
  assign pop      = !pipe_valid && !q_empty;

  wb_pending_queue #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .push_rd      (md_rd),
    .push_data    (md_result),
    .pop          (pop),
    .squash_en    (pipe_valid),
    .squash_rd    (pipe_addr),
    .head_valid   (head_valid),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .count        (q_count),
    .pending_mask (pending_mask)
  );

  // Port priority: pipeline, then queue head, then direct bypass; r0 writes are dropped.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_valid) begin
      rf_we_d    = (pipe_addr != '0);
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
    end else if (pop && head_valid) begin
      rf_we_d    = (head_rd != '0);
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end else if (bypass) begin
      rf_we_d    = (md_rd != '0);
      rf_waddr_d = md_rd;
      rf_wdata_d = md_result;
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter: expected regfile writes are queued
// when stimulus is issued and a negedge monitor pops/compares each rf write.
module tb_wb_commit_arbiter;

  logic        clock;
  logic        reset;
  logic        pipe_valid;
  logic [1:0]  pipe_sel;
  logic [4:0]  pipe_rd;
  logic        pipe_exc;
  logic [31:0] pipe_exc_code;
  logic [31:0] exec_out;
  logic [31:0] mem_out;
  logic [26:0] target;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic [2:0]  q_count;

  wb_commit_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .pipe_valid    (pipe_valid),
    .pipe_sel      (pipe_sel),
    .pipe_rd       (pipe_rd),
    .pipe_exc      (pipe_exc),
    .pipe_exc_code (pipe_exc_code),
    .exec_out      (exec_out),
    .mem_out       (mem_out),
    .target        (target),
    .md_valid      (md_valid),
    .md_rd         (md_rd),
    .md_result     (md_result),
    .md_ready      (md_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pending_mask  (pending_mask),
    .q_count       (q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;

  // Scoreboard monitor: every rf write must match the oldest expected write.
  always @(negedge clock) begin
    if (mon_en && rf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic exp_w(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0;
    pipe_exc   = 1'b0;
    pipe_sel   = 2'd0;
    md_valid   = 1'b0;
  endtask

  task automatic pipe_w(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = 1'b1;
    pipe_exc   = 1'b0;
    pipe_sel   = sel;
    pipe_rd    = rd;
    exec_out   = d;
  endtask

  task automatic md_w(input logic [4:0] rd, input logic [31:0] d);
    md_valid  = 1'b1;
    md_rd     = rd;
    md_result = d;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    pipe_rd = '0; pipe_exc_code = '0; exec_out = '0; mem_out = '0;
    target = '0; md_rd = '0; md_result = '0;
    step(); step(); step();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_q_count", 32'(q_count), 32'd0);
    chk("reset_mask", pending_mask, 32'd0);
    chk("reset_md_ready", 32'(md_ready), 32'd1);
    reset  = 1'b1;
    mon_en = 1'b1;

    // 1: pipeline sources
    pipe_w(2'd0, 5'd5, 32'h1234); exp_w(5'd5, 32'h1234); step();
    pipe_w(2'd2, 5'd5, 32'h0); target = 27'h7; exp_w(5'd30, 32'h7); step();
    chk("setx_waddr", 32'(rf_waddr), 32'd30);
    pipe_w(2'd1, 5'd6, 32'h0); mem_out = 32'hBEEF; exp_w(5'd6, 32'hBEEF); step();
    pipe_w(2'd3, 5'd7, 32'h400); exp_w(5'd31, 32'h400); step();
    idle(); step();

    // 2: bypass
    md_w(5'd8, 32'hAA); exp_w(5'd8, 32'hAA); step();
    idle();
    chk("bypass_q_count", 32'(q_count), 32'd0);
    step();

    // 3: queue behind pipeline, in-order drain
    pipe_w(2'd0, 5'd1, 32'h101); md_w(5'd9, 32'h99); exp_w(5'd1, 32'h101); step();
    pipe_w(2'd0, 5'd2, 32'h102); md_w(5'd10, 32'h1010); exp_w(5'd2, 32'h102); step();
    chk("t3_q_count", 32'(q_count), 32'd2);
    chk("t3_mask", pending_mask, 32'h600);
    md_valid = 1'b0;
    pipe_w(2'd0, 5'd3, 32'h103); exp_w(5'd3, 32'h103); step();
    pipe_w(2'd0, 5'd4, 32'h104); exp_w(5'd4, 32'h104); step();
    idle(); exp_w(5'd9, 32'h99); exp_w(5'd10, 32'h1010);
    step(); step();
    chk("t3_drained_count", 32'(q_count), 32'd0);
    chk("t3_drained_mask", pending_mask, 32'd0);

    // 4: WAW squash
    pipe_w(2'd0, 5'd3, 32'h33); md_w(5'd9, 32'h11); exp_w(5'd3, 32'h33); step();
    chk("t4_mask_set", pending_mask, 32'h200);
    md_valid = 1'b0;
    pipe_w(2'd0, 5'd9, 32'h22); exp_w(5'd9, 32'h22); step();
    chk("t4_mask_squashed", pending_mask, 32'd0);
    chk("t4_count_squashed", 32'(q_count), 32'd1);
    idle(); step();
    chk("t4_count_popped", 32'(q_count), 32'd0);

    // 5: fill queue, held md accepted after first pop
    for (int k = 0; k < 4; k++) begin
      pipe_w(2'd0, 5'(20 + k), 32'h200 + 32'(k));
      md_w(5'(11 + k), 32'h300 + 32'(k));
      exp_w(5'(20 + k), 32'h200 + 32'(k));
      step();
    end
    chk("t5_full_ready", 32'(md_ready), 32'd0);
    chk("t5_full_count", 32'(q_count), 32'd4);
    chk("t5_full_mask", pending_mask, 32'h7800);
    pipe_w(2'd0, 5'd24, 32'h204); md_w(5'd15, 32'h315); exp_w(5'd24, 32'h204); step();
    chk("t5_held_count", 32'(q_count), 32'd4);
    pipe_valid = 1'b0; exp_w(5'd11, 32'h300); step();
    chk("t5_pop_no_push_count", 32'(q_count), 32'd3);
    chk("t5_ready_again", 32'(md_ready), 32'd1);
    exp_w(5'd12, 32'h301); step();
    chk("t5_push_pop_count", 32'(q_count), 32'd3);
    chk("t5_push_pop_mask", pending_mask, 32'hE000);
    md_valid = 1'b0;
    exp_w(5'd13, 32'h302); exp_w(5'd14, 32'h303); exp_w(5'd15, 32'h315);
    step(); step(); step();
    chk("t5_drained_count", 32'(q_count), 32'd0);

    // 6: mid-operation reset, exception, r0 writes
    for (int k = 0; k < 3; k++) begin
      pipe_w(2'd0, 5'(21 + k), 32'h500 + 32'(k));
      md_w(5'(16 + k), 32'h600 + 32'(k));
      exp_w(5'(21 + k), 32'h500 + 32'(k));
      step();
    end
    chk("t6_pre_reset_count", 32'(q_count), 32'd3);
    idle(); reset = 1'b0; step();
    chk("t6_reset_rf_we", 32'(rf_we), 32'd0);
    chk("t6_reset_count", 32'(q_count), 32'd0);
    chk("t6_reset_mask", pending_mask, 32'd0);
    reset = 1'b1;
    pipe_w(2'd0, 5'd0, 32'h1); pipe_exc = 1'b1; pipe_exc_code = 32'hDEAD;
    exp_w(5'd30, 32'hDEAD); step();
    chk("t6_exc_waddr", 32'(rf_waddr), 32'd30);
    pipe_w(2'd0, 5'd0, 32'h55); md_w(5'd0, 32'h66); step();
    chk("t6_r0_rf_we", 32'(rf_we), 32'd0);
    chk("t6_r0_count", 32'(q_count), 32'd1);
    chk("t6_r0_mask", pending_mask, 32'd0);
    idle(); step();
    chk("t6_r0_popped", 32'(q_count), 32'd0);
    md_w(5'd0, 32'h77); step();
    idle();
    chk("t6_r0_bypass_we", 32'(rf_we), 32'd0);
    step(); step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
